// File: rtl/b16_dbg_host_if.sv
// ---------------------------------------------------------------------------
// b16_dbg_host_if
// Bundles every signal of the b16 debug host except the clock and reset.
//   Serial receive side : rx_data, rx_valid (to host), rx_ready (from host)
//   Serial transmit side: tx_data, tx_valid (from host), tx_ready (to host)
//   CPU debug port      : run, dr, dw, daddr, din, bp (from host), dout (to host)
//   CPU bus snoop       : cpu_addr, cpu_rd (to host), used for breakpoints
// The master modport is the host's view; slave is the CPU/UART/bench view.
// ---------------------------------------------------------------------------
interface b16_dbg_host_if #(
    parameter int L = 16
);
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         run;
    logic         dr;
    logic         dw;
    logic [2:0]   daddr;
    logic [L-1:0] din;
    logic [L-1:0] dout;
    logic [L-1:0] bp;
    logic [L-1:0] cpu_addr;
    logic         cpu_rd;

    modport master (
        input  rx_data, rx_valid, tx_ready, dout, cpu_addr, cpu_rd,
        output rx_ready, tx_data, tx_valid, run, dr, dw, daddr, din, bp
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dout, cpu_addr, cpu_rd,
        input  rx_ready, tx_data, tx_valid, run, dr, dw, daddr, din, bp
    );
endinterface

// File: rtl/b16_dbg_host.sv
// ---------------------------------------------------------------------------
// b16_dbg_host
// Byte-stream debug host for the b16 core. Decodes command bytes from a
// serial receiver, drives the CPU debug port as master, returns response
// bytes to a serial transmitter, and owns the breakpoint register.
// Ports:
//   clk    : sole clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : b16_dbg_host_if.master (rx/tx handshakes, debug port, bus snoop)
// Command byte: [7:5] opcode, [2:0] debug register select, [4:3] ignored.
//   000 READ, 001 WRITE, 010 RUN, 011 STEP, 100 STOP, 101 SETBP, 11x illegal.
// Responses: 0xAC ack, 0xEE error, 0xBB breakpoint event, READ data hi/lo.
// ---------------------------------------------------------------------------
module b16_dbg_host #(
    parameter int           l            = 16,
    parameter logic         RUN_ON_RESET = 1'b1,
    parameter logic [l-1:0] BP_RESET     = 16'hFFFF
) (
    input  logic            clk,
    input  logic            reset,
    b16_dbg_host_if.master  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GETH  = 3'd1;
    localparam logic [2:0] S_GETL  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_STEP  = 3'd4;
    localparam logic [2:0] S_SENDH = 3'd5;
    localparam logic [2:0] S_SENDL = 3'd6;
    localparam logic [2:0] S_SENDB = 3'd7;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_RUN   = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_STOP  = 3'd4;
    localparam logic [2:0] OP_SETBP = 3'd5;

    localparam logic [7:0] BYTE_ACK = 8'hAC;
    localparam logic [7:0] BYTE_ERR = 8'hEE;
    localparam logic [7:0] BYTE_EVT = 8'hBB;

    logic [2:0]   r_state;
    logic [2:0]   r_op;
    logic         r_err;
    logic [7:0]   r_hi;
    logic [7:0]   r_lo;
    logic         r_run;
    logic [l-1:0] r_bp;
    logic         r_evt;
    logic         r_dr;
    logic         r_dw;
    logic [2:0]   r_daddr;
    logic [l-1:0] r_din;
    logic [7:0]   r_txData;
    logic         r_txValid;
    logic         r_sendEvt;
    logic         r_pendValid;
    logic [7:0]   r_pendByte;

    logic         w_rxReady;
    logic         w_rxFire;
    logic         w_txFire;
    logic         w_hit;
    logic [2:0]   w_op;
    logic         w_immValid;
    logic [7:0]   w_immByte;

    assign w_op      = bus.rx_data[7:5];
    assign w_rxReady = ((r_state == S_IDLE) && !r_evt) ||
                       (r_state == S_GETH) || (r_state == S_GETL);
    assign w_rxFire  = bus.rx_valid && w_rxReady;
    assign w_txFire  = r_txValid && bus.tx_ready;
    assign w_hit     = r_run && bus.cpu_rd && (bus.cpu_addr == r_bp);

    // Commands decoded in IDLE that answer with a single byte straight away
    // (RUN, STOP, illegal opcodes, and a READ refused because the core runs).
    always_comb begin
        w_immValid = 1'b0;
        w_immByte  = BYTE_ACK;
        case (w_op)
            OP_READ: begin
                w_immValid = r_run;
                w_immByte  = BYTE_ERR;
            end
            OP_RUN, OP_STOP: begin
                w_immValid = 1'b1;
                w_immByte  = BYTE_ACK;
            end
            OP_WRITE, OP_STEP, OP_SETBP: begin
                w_immValid = 1'b0;
            end
            default: begin
                w_immValid = 1'b1;
                w_immByte  = BYTE_ERR;
            end
        endcase
    end

    // Main controller. The breakpoint update sits at the end of the block so
    // a hit overrides any run change made by a command at the same edge.
    // When a hit coincides with an immediately answered command, the event
    // byte is queued ahead of the command's own response via r_pendByte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_READ;
            r_err       <= 1'b0;
            r_hi        <= 8'h00;
            r_lo        <= 8'h00;
            r_run       <= RUN_ON_RESET;
            r_bp        <= BP_RESET;
            r_evt       <= 1'b0;
            r_dr        <= 1'b0;
            r_dw        <= 1'b0;
            r_daddr     <= 3'd0;
            r_din       <= '0;
            r_txData    <= 8'h00;
            r_txValid   <= 1'b0;
            r_sendEvt   <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendByte  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_evt) begin
                        r_txData  <= BYTE_EVT;
                        r_txValid <= 1'b1;
                        r_sendEvt <= 1'b1;
                        r_state   <= S_SENDB;
                    end else if (w_rxFire) begin
                        r_op <= w_op;
                        case (w_op)
                            OP_READ: begin
                                if (!r_run) begin
                                    r_daddr <= bus.rx_data[2:0];
                                    r_dr    <= 1'b1;
                                    r_state <= S_EXEC;
                                end
                            end
                            OP_WRITE: begin
                                if (!r_run) begin
                                    r_daddr <= bus.rx_data[2:0];
                                end
                                r_err   <= r_run;
                                r_state <= S_GETH;
                            end
                            OP_SETBP: begin
                                r_err   <= 1'b0;
                                r_state <= S_GETH;
                            end
                            OP_RUN: begin
                                r_run <= 1'b1;
                            end
                            OP_STOP: begin
                                r_run <= 1'b0;
                            end
                            OP_STEP: begin
                                r_run   <= 1'b1;
                                r_state <= S_STEP;
                            end
                            default: begin
                                r_run <= r_run;
                            end
                        endcase
                        if (w_immValid) begin
                            r_state   <= S_SENDB;
                            r_txValid <= 1'b1;
                            if (w_hit) begin
                                r_txData    <= BYTE_EVT;
                                r_sendEvt   <= 1'b1;
                                r_pendValid <= 1'b1;
                                r_pendByte  <= w_immByte;
                            end else begin
                                r_txData <= w_immByte;
                            end
                        end
                    end
                end
                S_GETH: begin
                    if (w_rxFire) begin
                        r_hi    <= bus.rx_data;
                        r_state <= S_GETL;
                    end
                end
                S_GETL: begin
                    if (w_rxFire) begin
                        if (r_op == OP_SETBP) begin
                            r_bp      <= {r_hi, bus.rx_data};
                            r_txData  <= BYTE_ACK;
                            r_txValid <= 1'b1;
                            r_state   <= S_SENDB;
                        end else if (r_err) begin
                            r_txData  <= BYTE_ERR;
                            r_txValid <= 1'b1;
                            r_state   <= S_SENDB;
                        end else begin
                            r_din   <= {r_hi, bus.rx_data};
                            r_dw    <= 1'b1;
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_dr      <= 1'b0;
                    r_dw      <= 1'b0;
                    r_txValid <= 1'b1;
                    if (r_op == OP_READ) begin
                        r_txData <= bus.dout[l-1 -: 8];
                        r_lo     <= bus.dout[7:0];
                        r_state  <= S_SENDH;
                    end else begin
                        r_txData <= BYTE_ACK;
                        r_state  <= S_SENDB;
                    end
                end
                S_STEP: begin
                    r_run     <= 1'b0;
                    r_txData  <= BYTE_ACK;
                    r_txValid <= 1'b1;
                    r_state   <= S_SENDB;
                end
                S_SENDH: begin
                    if (w_txFire) begin
                        r_txData <= r_lo;
                        r_state  <= S_SENDL;
                    end
                end
                S_SENDL: begin
                    if (w_txFire) begin
                        r_txValid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    if (w_txFire) begin
                        r_sendEvt <= 1'b0;
                        if (r_sendEvt) begin
                            r_evt <= 1'b0;
                        end
                        if (r_pendValid) begin
                            r_txData    <= r_pendByte;
                            r_pendValid <= 1'b0;
                        end else begin
                            r_txValid <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
            endcase
            if (w_hit) begin
                r_run <= 1'b0;
                r_evt <= 1'b1;
            end
        end
    end

    assign bus.rx_ready = w_rxReady;
    assign bus.tx_data  = r_txData;
    assign bus.tx_valid = r_txValid;
    assign bus.run      = r_run;
    assign bus.dr       = r_dr;
    assign bus.dw       = r_dw;
    assign bus.daddr    = r_daddr;
    assign bus.din      = r_din;
    assign bus.bp       = r_bp;

endmodule

// File: tb/tb_b16_dbg_host.sv
// ---------------------------------------------------------------------------
// tb_b16_dbg_host
// Directed bench for b16_dbg_host: a table of command vectors with expected
// responses and debug-port effects, plus hand-written multi-cycle sequences
// for breakpoints, STEP, transmit stall and reset in mid-command.
// ---------------------------------------------------------------------------
module tb_b16_dbg_host;

    typedef struct {
        int          nCmd;
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [15:0] doutVal;
        int          nResp;
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic        expRun;
        int          dDr;
        int          dDw;
        logic [15:0] expBp;
        logic [15:0] expDin;
        logic [2:0]  expDaddr;
    } vec_t;

    logic clk;
    logic reset;
    int   totalCount;
    int   badCount;
    int   drCount;
    int   dwCount;
    int   runHigh;
    int   bothCount;
    int   drWhileRun;

    b16_dbg_host_if #(.L(16)) bif ();

    b16_dbg_host #(
        .l(16),
        .RUN_ON_RESET(1'b1),
        .BP_RESET(16'hFFFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe and run monitor, sampled on the falling edge.
    initial begin
        drCount    = 0;
        dwCount    = 0;
        runHigh    = 0;
        bothCount  = 0;
        drWhileRun = 0;
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (bif.dr) drCount++;
            if (bif.dw) dwCount++;
            if (bif.run) runHigh++;
            if (bif.dr && bif.dw) bothCount++;
            if ((bif.dr || bif.dw) && bif.run) drWhileRun++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Sends one byte over the receive handshake, bounded wait on rx_ready.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        while (!bif.rx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL rx timeout: byte %0h not accepted", b);
        end
        @(posedge clk); #1;
        bif.rx_valid = 1'b0;
    endtask

    // Takes one byte from the transmit handshake, bounded wait on tx_valid.
    task automatic receiveByte(output logic [7:0] b);
        int n;
        n = 0;
        bif.tx_ready = 1'b1;
        while (!bif.tx_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL tx timeout: got no byte, expected one");
        end
        b = bif.tx_data;
        @(posedge clk); #1;
        bif.tx_ready = 1'b0;
    endtask

    initial begin
        vec_t       vecs [11];
        logic [7:0] got;
        int         drBefore;
        int         dwBefore;
        int         runBefore;
        int         n;
        logic       stable;

        totalCount = 0;
        badCount   = 0;

        //            n  c0     c1     c2     dout      nR r0     r1     run dDr dDw bp         din        daddr
        vecs[0]  = '{1, 8'h80, 8'h00, 8'h00, 16'h0000, 1, 8'hAC, 8'h00, 0, 0, 0, 16'hFFFF, 16'h0000, 3'd0};
        vecs[1]  = '{1, 8'h05, 8'h00, 8'h00, 16'h1234, 2, 8'h12, 8'h34, 0, 1, 0, 16'hFFFF, 16'h0000, 3'd5};
        vecs[2]  = '{3, 8'h24, 8'h3F, 8'hFE, 16'h1234, 1, 8'hAC, 8'h00, 0, 0, 1, 16'hFFFF, 16'h3FFE, 3'd4};
        vecs[3]  = '{1, 8'h40, 8'h00, 8'h00, 16'h1234, 1, 8'hAC, 8'h00, 1, 0, 0, 16'hFFFF, 16'h3FFE, 3'd4};
        vecs[4]  = '{3, 8'h24, 8'h11, 8'h22, 16'h1234, 1, 8'hEE, 8'h00, 1, 0, 0, 16'hFFFF, 16'h3FFE, 3'd4};
        vecs[5]  = '{1, 8'h03, 8'h00, 8'h00, 16'h5555, 1, 8'hEE, 8'h00, 1, 0, 0, 16'hFFFF, 16'h3FFE, 3'd4};
        vecs[6]  = '{1, 8'h80, 8'h00, 8'h00, 16'h5555, 1, 8'hAC, 8'h00, 0, 0, 0, 16'hFFFF, 16'h3FFE, 3'd4};
        vecs[7]  = '{1, 8'hC0, 8'h00, 8'h00, 16'h5555, 1, 8'hEE, 8'h00, 0, 0, 0, 16'hFFFF, 16'h3FFE, 3'd4};
        vecs[8]  = '{1, 8'hFF, 8'h00, 8'h00, 16'h5555, 1, 8'hEE, 8'h00, 0, 0, 0, 16'hFFFF, 16'h3FFE, 3'd4};
        vecs[9]  = '{3, 8'hA0, 8'h01, 8'h00, 16'h5555, 1, 8'hAC, 8'h00, 0, 0, 0, 16'h0100, 16'h3FFE, 3'd4};
        vecs[10] = '{1, 8'h07, 8'h00, 8'h00, 16'hABCD, 2, 8'hAB, 8'hCD, 0, 1, 0, 16'h0100, 16'h3FFE, 3'd7};

        bif.rx_data  = 8'h00;
        bif.rx_valid = 1'b0;
        bif.tx_ready = 1'b0;
        bif.dout     = 16'h0000;
        bif.cpu_addr = 16'h0000;
        bif.cpu_rd   = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        checkOutput("reset run", bif.run, 1'b1);
        checkOutput("reset bp", bif.bp, 16'hFFFF);
        checkOutput("reset txValid", bif.tx_valid, 1'b0);
        checkOutput("reset txData", bif.tx_data, 8'h00);
        checkOutput("reset rxReady", bif.rx_ready, 1'b1);
        checkOutput("reset strobes", {bif.dr, bif.dw}, 2'b00);
        checkOutput("reset daddr", bif.daddr, 3'd0);
        checkOutput("reset din", bif.din, 16'h0000);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven command vectors
        for (int i = 0; i < 11; i++) begin
            drBefore = drCount;
            dwBefore = dwCount;
            bif.dout = vecs[i].doutVal;
            applyStimulus(vecs[i].c0);
            if (vecs[i].nCmd > 1) applyStimulus(vecs[i].c1);
            if (vecs[i].nCmd > 2) applyStimulus(vecs[i].c2);
            receiveByte(got);
            checkOutput($sformatf("v%0d resp0", i), got, vecs[i].r0);
            if (vecs[i].nResp > 1) begin
                receiveByte(got);
                checkOutput($sformatf("v%0d resp1", i), got, vecs[i].r1);
            end
            repeat (2) @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d run", i), bif.run, vecs[i].expRun);
            checkOutput($sformatf("v%0d dr pulses", i), drCount - drBefore, vecs[i].dDr);
            checkOutput($sformatf("v%0d dw pulses", i), dwCount - dwBefore, vecs[i].dDw);
            checkOutput($sformatf("v%0d bp", i), bif.bp, vecs[i].expBp);
            checkOutput($sformatf("v%0d din", i), bif.din, vecs[i].expDin);
            checkOutput($sformatf("v%0d daddr", i), bif.daddr, vecs[i].expDaddr);
            checkOutput($sformatf("v%0d idle tx", i), bif.tx_valid, 1'b0);
        end

        // Transmit stall during a READ response
        bif.dout = 16'h1234;
        applyStimulus(8'h05);
        n = 0;
        while (!bif.tx_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        stable = 1'b1;
        repeat (10) begin
            if (!bif.tx_valid || bif.tx_data !== 8'h12 || bif.rx_ready) stable = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("stall stable", stable, 1'b1);
        receiveByte(got);
        checkOutput("stall hi", got, 8'h12);
        receiveByte(got);
        checkOutput("stall lo", got, 8'h34);

        // Breakpoint hit while running
        applyStimulus(8'h40);
        receiveByte(got);
        checkOutput("bp run ack", got, 8'hAC);
        bif.cpu_addr = 16'h0100;
        bif.cpu_rd   = 1'b1;
        @(posedge clk); #1;
        bif.cpu_rd   = 1'b0;
        checkOutput("bp run dropped", bif.run, 1'b0);
        receiveByte(got);
        checkOutput("bp event", got, 8'hBB);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("bp quiet after event", bif.tx_valid, 1'b0);
        checkOutput("bp readback", bif.bp, 16'h0100);

        // STEP from stopped: run high exactly one cycle
        runBefore = runHigh;
        applyStimulus(8'h60);
        receiveByte(got);
        checkOutput("step ack", got, 8'hAC);
        checkOutput("step run cycles", runHigh - runBefore, 1);
        checkOutput("step run low", bif.run, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("step no event", bif.tx_valid, 1'b0);

        // STEP with a breakpoint match in the step cycle
        runBefore    = runHigh;
        bif.cpu_addr = 16'h0100;
        bif.cpu_rd   = 1'b1;
        applyStimulus(8'h60);
        receiveByte(got);
        checkOutput("stepbp ack", got, 8'hAC);
        receiveByte(got);
        checkOutput("stepbp event", got, 8'hBB);
        bif.cpu_rd = 1'b0;
        checkOutput("stepbp run cycles", runHigh - runBefore, 1);

        // Breakpoint hit at the same edge as a STOP accept
        applyStimulus(8'h40);
        receiveByte(got);
        checkOutput("simul run ack", got, 8'hAC);
        checkOutput("simul rxReady", bif.rx_ready, 1'b1);
        bif.rx_data  = 8'h80;
        bif.rx_valid = 1'b1;
        bif.cpu_addr = 16'h0100;
        bif.cpu_rd   = 1'b1;
        @(posedge clk); #1;
        bif.rx_valid = 1'b0;
        bif.cpu_rd   = 1'b0;
        receiveByte(got);
        checkOutput("simul event first", got, 8'hBB);
        receiveByte(got);
        checkOutput("simul stop ack", got, 8'hAC);
        checkOutput("simul run", bif.run, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("simul quiet", bif.tx_valid, 1'b0);

        // Reset between the two WRITE data bytes
        dwBefore = dwCount;
        applyStimulus(8'h24);
        applyStimulus(8'h3F);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midreset txValid", bif.tx_valid, 1'b0);
        checkOutput("midreset run", bif.run, 1'b1);
        checkOutput("midreset bp", bif.bp, 16'hFFFF);
        checkOutput("midreset din", bif.din, 16'h0000);
        checkOutput("midreset rxReady", bif.rx_ready, 1'b1);
        applyStimulus(8'h80);
        receiveByte(got);
        checkOutput("midreset stop ack", got, 8'hAC);
        checkOutput("midreset stop run", bif.run, 1'b0);
        checkOutput("midreset no dw", dwCount - dwBefore, 0);

        // Strobe sanity over the whole run
        checkOutput("dr dw overlap", bothCount, 0);
        checkOutput("strobe while running", drWhileRun, 0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
